// File: rtl/pep_ks_boram_wr_ctrl.sv
// rtl/pep_ks_boram_wr_ctrl.sv - KS-side writer for the mmacc body RAM, corrections ordered before body
module pep_ks_boram_wr_ctrl #(
    parameter int TOTAL_PBS_NB    = 16,
    parameter int PID_W           = 4,
    parameter int MOD_KSK_W       = 21,
    parameter int KS_MAX_ERROR_W  = 8,
    parameter int KS_BLOCK_COL_NB = 4
) (
    input  logic                      clk,
    input  logic                      s_rst_n,
    input  logic                      reset_cache,

    input  logic [MOD_KSK_W-1:0]      body_data,
    input  logic [PID_W-1:0]          body_pid,
    input  logic                      body_vld,
    output logic                      body_rdy,

    input  logic [KS_MAX_ERROR_W-1:0] corr_data,
    input  logic [PID_W-1:0]          corr_pid,
    input  logic                      corr_vld,
    output logic                      corr_rdy,

    output logic                      ks_boram_wr_en,
    output logic [MOD_KSK_W-1:0]      ks_boram_wr_data,
    output logic [PID_W-1:0]          ks_boram_wr_pid,
    output logic                      ks_boram_wr_parity,

    output logic                      ks_boram_corr_wr_en,
    output logic [KS_MAX_ERROR_W-1:0] ks_boram_corr_wr_data,
    output logic [PID_W-1:0]          ks_boram_corr_wr_pid,

    output logic [TOTAL_PBS_NB-1:0]   pid_busy
);

    localparam int                CNT_W    = $clog2(KS_BLOCK_COL_NB + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(KS_BLOCK_COL_NB);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [PID_W:0]    PID_LIM  = (PID_W + 1)'(TOTAL_PBS_NB);

    // Per-pid state: corrections received since the last body write, and body parity.
    logic [CNT_W-1:0]        corr_cnt_q [TOTAL_PBS_NB];
    logic [CNT_W-1:0]        corr_cnt_d [TOTAL_PBS_NB];
    logic [TOTAL_PBS_NB-1:0] parity_q;
    logic [TOTAL_PBS_NB-1:0] parity_d;

    // Registered write ports.
    logic                      wr_en_q;
    logic [MOD_KSK_W-1:0]      wr_data_q;
    logic [PID_W-1:0]          wr_pid_q;
    logic                      wr_parity_q;
    logic                      corr_wr_en_q;
    logic [KS_MAX_ERROR_W-1:0] corr_wr_data_q;
    logic [PID_W-1:0]          corr_wr_pid_q;

    logic             body_pid_ok;
    logic             corr_pid_ok;
    logic [CNT_W-1:0] body_cnt;
    logic [CNT_W-1:0] corr_cnt;
    logic             body_hs;
    logic             corr_hs;

    // Ready depends only on registered counters and the pid tags, never on vld.
    always_comb begin
        body_pid_ok = ({1'b0, body_pid} < PID_LIM);
        corr_pid_ok = ({1'b0, corr_pid} < PID_LIM);
        body_cnt    = body_pid_ok ? corr_cnt_q[body_pid] : '0;
        corr_cnt    = corr_pid_ok ? corr_cnt_q[corr_pid] : '0;
        body_rdy    = !reset_cache && body_pid_ok && (body_cnt == CNT_FULL);
        corr_rdy    = !reset_cache && corr_pid_ok && (corr_cnt < CNT_FULL);
        body_hs     = body_vld && body_rdy;
        corr_hs     = corr_vld && corr_rdy;
    end

    // Next-state of per-pid counters/parity; a body and a corr never hit the same pid in one cycle.
    always_comb begin
        corr_cnt_d = corr_cnt_q;
        parity_d   = parity_q;
        if (reset_cache) begin
            for (int i = 0; i < TOTAL_PBS_NB; i++) begin
                corr_cnt_d[i] = '0;
            end
            parity_d = '0;
        end else begin
            if (corr_hs) begin
                corr_cnt_d[corr_pid] = corr_cnt_q[corr_pid] + CNT_ONE;
            end
            if (body_hs) begin
                corr_cnt_d[body_pid] = '0;
                parity_d[body_pid]   = ~parity_q[body_pid];
            end
        end
    end

    // Per-pid state registers.
    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            for (int i = 0; i < TOTAL_PBS_NB; i++) begin
                corr_cnt_q[i] <= '0;
            end
            parity_q <= '0;
        end else begin
            corr_cnt_q <= corr_cnt_d;
            parity_q   <= parity_d;
        end
    end

    // Write strobes one cycle after the handshake; data/pid hold between strobes.
    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            wr_en_q        <= 1'b0;
            wr_data_q      <= '0;
            wr_pid_q       <= '0;
            wr_parity_q    <= 1'b0;
            corr_wr_en_q   <= 1'b0;
            corr_wr_data_q <= '0;
            corr_wr_pid_q  <= '0;
        end else begin
            wr_en_q      <= body_hs;
            corr_wr_en_q <= corr_hs;
            if (body_hs) begin
                wr_data_q   <= body_data;
                wr_pid_q    <= body_pid;
                wr_parity_q <= ~parity_q[body_pid];
            end
            if (corr_hs) begin
                corr_wr_data_q <= corr_data;
                corr_wr_pid_q  <= corr_pid;
            end
        end
    end

    // A pid is busy while it has collected corrections that its body has not yet consumed.
    always_comb begin
        for (int i = 0; i < TOTAL_PBS_NB; i++) begin
            pid_busy[i] = (corr_cnt_q[i] != '0);
        end
    end

    assign ks_boram_wr_en        = wr_en_q;
    assign ks_boram_wr_data      = wr_data_q;
    assign ks_boram_wr_pid       = wr_pid_q;
    assign ks_boram_wr_parity    = wr_parity_q;
    assign ks_boram_corr_wr_en   = corr_wr_en_q;
    assign ks_boram_corr_wr_data = corr_wr_data_q;
    assign ks_boram_corr_wr_pid  = corr_wr_pid_q;

    a_body_pid_range : assert property (@(posedge clk) disable iff (!s_rst_n) body_vld |-> body_pid_ok);
    a_corr_pid_range : assert property (@(posedge clk) disable iff (!s_rst_n) corr_vld |-> corr_pid_ok);

endmodule

// File: tb/tb_pep_ks_boram_wr_ctrl.sv
// tb/tb_pep_ks_boram_wr_ctrl.sv - directed and random bench for pep_ks_boram_wr_ctrl
module tb_pep_ks_boram_wr_ctrl;

    localparam int NP = 16;
    localparam int NB = 4;

    logic        clk = 1'b0;
    logic        s_rst_n;
    logic        reset_cache;
    logic [20:0] body_data;
    logic [3:0]  body_pid;
    logic        body_vld;
    logic        body_rdy;
    logic [7:0]  corr_data;
    logic [3:0]  corr_pid;
    logic        corr_vld;
    logic        corr_rdy;
    logic        ks_boram_wr_en;
    logic [20:0] ks_boram_wr_data;
    logic [3:0]  ks_boram_wr_pid;
    logic        ks_boram_wr_parity;
    logic        ks_boram_corr_wr_en;
    logic [7:0]  ks_boram_corr_wr_data;
    logic [3:0]  ks_boram_corr_wr_pid;
    logic [15:0] pid_busy;

    always #5 clk = ~clk;

    pep_ks_boram_wr_ctrl #(
        .TOTAL_PBS_NB(NP), .PID_W(4), .MOD_KSK_W(21), .KS_MAX_ERROR_W(8), .KS_BLOCK_COL_NB(NB)
    ) dut (
        .clk(clk), .s_rst_n(s_rst_n), .reset_cache(reset_cache),
        .body_data(body_data), .body_pid(body_pid), .body_vld(body_vld), .body_rdy(body_rdy),
        .corr_data(corr_data), .corr_pid(corr_pid), .corr_vld(corr_vld), .corr_rdy(corr_rdy),
        .ks_boram_wr_en(ks_boram_wr_en), .ks_boram_wr_data(ks_boram_wr_data),
        .ks_boram_wr_pid(ks_boram_wr_pid), .ks_boram_wr_parity(ks_boram_wr_parity),
        .ks_boram_corr_wr_en(ks_boram_corr_wr_en), .ks_boram_corr_wr_data(ks_boram_corr_wr_data),
        .ks_boram_corr_wr_pid(ks_boram_corr_wr_pid), .pid_busy(pid_busy)
    );

    // Reference model: corrections pending per pid, and number of bodies written per pid.
    int          pend_m   [NP];
    int          bodies_m [NP];
    logic [20:0] last_wd;
    logic [3:0]  last_wp;
    logic        last_par;
    logic [7:0]  last_cd;
    logic [3:0]  last_cp;
    int          n_checks = 0;
    int          n_errs   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, check ready, then check write ports and busy vector.
    task automatic cyc(input logic bv, input int bp, input logic [20:0] bd,
                       input logic cv, input int cp, input logic [7:0] cd, input logic rc);
        logic        exp_brdy;
        logic        exp_crdy;
        logic        bhs;
        logic        chs;
        logic [15:0] exp_busy;
        body_vld    = bv;
        body_pid    = 4'(bp);
        body_data   = bd;
        corr_vld    = cv;
        corr_pid    = 4'(cp);
        corr_data   = cd;
        reset_cache = rc;
        @(negedge clk);
        exp_brdy = !rc && (pend_m[bp] == NB);
        exp_crdy = !rc && (pend_m[cp] < NB);
        chk("body_rdy", 32'(body_rdy), 32'(exp_brdy));
        chk("corr_rdy", 32'(corr_rdy), 32'(exp_crdy));
        bhs = bv && exp_brdy;
        chs = cv && exp_crdy;
        @(posedge clk);
        if (rc) begin
            for (int i = 0; i < NP; i++) begin
                pend_m[i]   = 0;
                bodies_m[i] = 0;
            end
        end else begin
            if (chs) begin
                pend_m[cp]++;
                last_cd = cd;
                last_cp = 4'(cp);
            end
            if (bhs) begin
                pend_m[bp] = 0;
                bodies_m[bp]++;
                last_wd  = bd;
                last_wp  = 4'(bp);
                last_par = (bodies_m[bp] % 2) == 1;
            end
        end
        #1;
        for (int i = 0; i < NP; i++) exp_busy[i] = (pend_m[i] != 0);
        chk("wr_en",        32'(ks_boram_wr_en),        32'(bhs));
        chk("wr_data",      32'(ks_boram_wr_data),      32'(last_wd));
        chk("wr_pid",       32'(ks_boram_wr_pid),       32'(last_wp));
        chk("wr_parity",    32'(ks_boram_wr_parity),    32'(last_par));
        chk("corr_wr_en",   32'(ks_boram_corr_wr_en),   32'(chs));
        chk("corr_wr_data", 32'(ks_boram_corr_wr_data), 32'(last_cd));
        chk("corr_wr_pid",  32'(ks_boram_corr_wr_pid),  32'(last_cp));
        chk("pid_busy",     32'(pid_busy),              32'(exp_busy));
    endtask

    initial begin
        for (int i = 0; i < NP; i++) begin
            pend_m[i]   = 0;
            bodies_m[i] = 0;
        end
        last_wd = '0; last_wp = '0; last_par = 1'b0; last_cd = '0; last_cp = '0;
        s_rst_n = 1'b0; reset_cache = 1'b0;
        body_vld = 1'b0; body_pid = '0; body_data = '0;
        corr_vld = 1'b0; corr_pid = '0; corr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en",      32'(ks_boram_wr_en),        32'd0);
        chk("rst_wr_data",    32'(ks_boram_wr_data),      32'd0);
        chk("rst_wr_parity",  32'(ks_boram_wr_parity),    32'd0);
        chk("rst_corr_wr_en", 32'(ks_boram_corr_wr_en),   32'd0);
        chk("rst_corr_data",  32'(ks_boram_corr_wr_data), 32'd0);
        chk("rst_pid_busy",   32'(pid_busy),              32'd0);
        s_rst_n = 1'b1;
        cyc(0, 0, 21'd0, 0, 0, 8'd0, 0);

        // pid 3 body with no corrections is held off
        cyc(1, 3, 21'h12345, 0, 0, 8'd0, 0);
        cyc(1, 3, 21'h12345, 0, 0, 8'd0, 0);
        // three rounds on pid 3: parity 1, 0, 1
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < NB; k++) cyc(0, 3, 21'd0, 1, 3, 8'(8'hF0 + k + r), 0);
            cyc(1, 3, 21'(21'h1A000 + r), 0, 0, 8'd0, 0);
        end

        // pid 2: fifth correction waits for the body
        for (int k = 0; k < NB; k++) cyc(0, 0, 21'd0, 1, 2, 8'(8'h80 + k), 0);
        cyc(0, 0, 21'd0, 1, 2, 8'h7F, 0);
        cyc(0, 0, 21'd0, 1, 2, 8'h7F, 0);
        cyc(1, 2, 21'h0BEEF, 1, 2, 8'h7F, 0);
        cyc(0, 0, 21'd0, 1, 2, 8'h7F, 0);

        // body pid 1 and correction pid 5 in the same cycle
        for (int k = 0; k < NB; k++) cyc(0, 0, 21'd0, 1, 1, 8'(k), 0);
        cyc(1, 1, 21'h1FFFF, 1, 5, 8'hC3, 0);

        // reset_cache with pid 7 partially filled
        cyc(0, 0, 21'd0, 1, 7, 8'h11, 0);
        cyc(0, 0, 21'd0, 1, 7, 8'h22, 0);
        cyc(1, 1, 21'h00055, 1, 7, 8'h33, 1);
        cyc(1, 7, 21'h00777, 0, 0, 8'd0, 0);
        for (int k = 0; k < NB; k++) cyc(0, 0, 21'd0, 1, 7, 8'(8'h40 + k), 0);
        cyc(1, 7, 21'h00777, 0, 0, 8'd0, 0);

        // random soak
        for (int n = 0; n < 800; n++) begin
            int bp;
            int cp;
            bp = int'($urandom_range(0, NP - 1));
            cp = ($urandom_range(0, 1) == 1) ? bp : int'($urandom_range(0, NP - 1));
            cyc(1'($urandom_range(0, 1)), bp, 21'($urandom),
                1'($urandom_range(0, 3) != 0), cp, 8'($urandom),
                1'($urandom_range(0, 99) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
